pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. Combines the load-use hazard, taken branches resolved in EX, jumps decoded in ID, and a variable-latency data-memory handshake. It drives the write-enable, hold and flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also sequences post-reset pipeline drain and memory-timeout lockout.

---
 rtl/pipeline_stall_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, branch/jump flush,
// memory-wait freeze with timeout lockout. Define STALL_STATS_EN for stall/flush counters.
module pipeline_stall_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             branch_taken,
  input  logic             jump_id,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             mem_wb_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_MEM_WAIT, S_ERROR} state_t;

  state_t          state, next_state;
  logic [IW-1:0]   init_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            load_use;
  logic            mem_stall;
  logic            frozen;
  logic            apply_rules;
  logic            flush_ev;

  assign load_use  = id_ex_memread && (id_ex_rt != 5'd0) &&
                     ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  assign mem_stall = mem_req && !mem_ready;

  // Freeze covers the stalling RUN cycle, every unfinished MEM_WAIT cycle and ERROR.
  assign frozen      = ((state == S_RUN) && mem_stall) ||
                       ((state == S_MEM_WAIT) && !mem_ready) ||
                       (state == S_ERROR);
  assign apply_rules = ((state == S_RUN) && !mem_stall) ||
                       ((state == S_MEM_WAIT) && mem_ready);
  assign flush_ev    = apply_rules && (branch_taken || (!load_use && jump_id));

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    next_state    = state;

    case (state)
      S_INIT: begin
        if (init_cnt == IW'(INIT_CYCLES - 1)) next_state = S_RUN;
      end
      S_RUN: begin
        if (mem_stall) next_state = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_ready)                          next_state = S_RUN;
        else if (wait_cnt == WW'(MEM_TIMEOUT)) next_state = S_ERROR;
      end
      default: next_state = S_ERROR;
    endcase

    if (state == S_INIT) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (frozen) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_hold    = 1'b1;
      ex_mem_hold   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (apply_rules) begin
      // A taken branch discards the instructions that would raise load-use or jump.
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else if (jump_id) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: only control state is reset here; datapath registers elsewhere need no reset.
    if (rst) begin
      state           <= S_INIT;
      init_cnt        <= '0;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state <= next_state;
      if (state == S_INIT && next_state == S_INIT)
        init_cnt <= init_cnt + IW'(1);
      if (state == S_RUN && next_state == S_MEM_WAIT)
        wait_cnt <= WW'(1);
      else if (state == S_MEM_WAIT && next_state == S_MEM_WAIT)
        wait_cnt <= wait_cnt + WW'(1);
      if (next_state == S_ERROR)
        mem_timeout_err <= 1'b1;
    end
  end

`ifdef STALL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if ((state == S_RUN || state == S_MEM_WAIT) && !pc_write && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_ev && flush_events != '1)
        flush_events <= flush_events + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
  logic unused_stats;
  assign unused_stats = flush_ev;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares (counters checked when STALL_STATS_EN is defined).
module tb_pipeline_stall_ctrl;

  localparam int CNT_W = 16;

  // Output bit order: pc_write, if_id_write, if_id_flush, id_ex_flush,
  // id_ex_hold, ex_mem_hold, mem_wb_bubble, mem_timeout_err
  localparam logic [7:0] O_NORM = 8'b1100_0000;
  localparam logic [7:0] O_INIT = 8'b0011_0000;
  localparam logic [7:0] O_FRZ  = 8'b0000_1110;
  localparam logic [7:0] O_BR   = 8'b1111_0000;
  localparam logic [7:0] O_LU   = 8'b0001_0000;
  localparam logic [7:0] O_JMP  = 8'b1110_0000;
  localparam logic [7:0] O_ERR  = 8'b0000_1111;

  typedef struct {
    logic [7:0]       outs;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    string            name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_ex_memread = 1'b0;
  logic [4:0] id_ex_rt = '0, if_id_rs = '0, if_id_rt = '0;
  logic branch_taken = 1'b0, jump_id = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic id_ex_hold, ex_mem_hold, mem_wb_bubble, mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int acc_stall = 0;
  int acc_flush = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .branch_taken(branch_taken), .jump_id(jump_id),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
    .mem_wb_bubble(mem_wb_bubble), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One vector per cycle; st/fl mark whether this cycle should bump the counters.
  task automatic drive(input string name, input logic r, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic br,
                       input logic jmp, input logic rq, input logic rdy,
                       input logic [7:0] outs, input bit st, input bit fl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_ex_memread = mr; id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt;
    branch_taken = br; jump_id = jmp; mem_req = rq; mem_ready = rdy;
    if (r) begin
      acc_stall = 0;
      acc_flush = 0;
    end
    e.outs = outs;
    e.name = name;
`ifdef STALL_STATS_EN
    e.stall = CNT_W'(acc_stall);
    e.flush = CNT_W'(acc_flush);
`else
    e.stall = '0;
    e.flush = '0;
`endif
    exp_q.push_back(e);
    if (!r) begin
      acc_stall += int'(st);
      acc_flush += int'(fl);
    end
  endtask

  task automatic idle(input string name, input logic [7:0] outs);
    drive(name, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, outs, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".outs"}, {24'd0, pc_write, if_id_write, if_id_flush, id_ex_flush,
              id_ex_hold, ex_mem_hold, mem_wb_bubble, mem_timeout_err}, {24'd0, e.outs});
        check({e.name, ".stall_cycles"}, 32'(stall_cycles), 32'(e.stall));
        check({e.name, ".flush_events"}, 32'(flush_events), 32'(e.flush));
      end
    end
  end

  initial begin : stimulus
    //    name        rst mr ert rs rt br jmp rq rdy  outs  st fl
    drive("rst0",     1, 0, 0, 0, 0, 0, 0, 0, 0, O_INIT, 0, 0);
    drive("rst1",     1, 0, 0, 0, 0, 0, 0, 0, 0, O_INIT, 0, 0);
    drive("rst2",     1, 0, 0, 0, 0, 0, 0, 0, 0, O_INIT, 0, 0);
    idle("drain0", O_INIT);
    idle("drain1", O_INIT);
    idle("run0",   O_NORM);

    drive("lu_rs",    0, 1, 8, 8, 0, 0, 0, 0, 0, O_LU,   1, 0);
    idle("lu_clear", O_NORM);
    drive("lu_r0",    0, 1, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0);
    drive("lu_rt",    0, 1, 9, 3, 9, 0, 0, 0, 0, O_LU,   1, 0);
    drive("no_load",  0, 0, 9, 9, 9, 0, 0, 0, 0, O_NORM, 0, 0);
    drive("lu_miss",  0, 1, 9, 3, 4, 0, 0, 0, 0, O_NORM, 0, 0);

    drive("br_all",   0, 1, 8, 8, 0, 1, 1, 0, 0, O_BR,   0, 1);
    drive("jump",     0, 0, 0, 0, 0, 0, 1, 0, 0, O_JMP,  0, 1);
    drive("lu_jump",  0, 1, 5, 5, 0, 0, 1, 0, 0, O_LU,   1, 0);
    idle("run1", O_NORM);

    drive("mw0",      0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("mw1",      0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("mw2",      0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("mw_rel",   0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM, 0, 0);
    drive("b2b0",     0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("b2b1",     0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("b2b2",     0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("b2b3",     0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM, 0, 0);

    drive("fb0",      0, 0, 0, 0, 0, 1, 0, 1, 0, O_FRZ,  1, 0);
    drive("fb1",      0, 0, 0, 0, 0, 1, 0, 1, 0, O_FRZ,  1, 0);
    drive("fb_rel",   0, 0, 0, 0, 0, 1, 0, 1, 1, O_BR,   0, 1);
    drive("fl0",      0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("fl_rel",   0, 1, 7, 0, 7, 0, 0, 1, 1, O_LU,   1, 0);
    drive("fj0",      0, 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ,  1, 0);
    drive("fj_rel",   0, 0, 0, 0, 0, 0, 1, 0, 1, O_JMP,  0, 1);
    idle("run2", O_NORM);

    drive("to0",      0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("to1",      0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("to2",      0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("to3",      0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("to4",      0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("err0",     0, 0, 0, 0, 0, 0, 0, 1, 1, O_ERR,  0, 0);
    drive("err1",     0, 0, 0, 0, 0, 1, 1, 0, 1, O_ERR,  0, 0);
    drive("err2",     0, 1, 8, 8, 0, 0, 0, 0, 0, O_ERR,  0, 0);
    drive("err_rst",  1, 0, 0, 0, 0, 0, 0, 0, 0, O_INIT, 0, 0);
    idle("re_drain0", O_INIT);
    idle("re_drain1", O_INIT);
    idle("re_run",    O_NORM);

    drive("mr0",      0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("mr1",      0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  1, 0);
    drive("mr_rst",   1, 0, 0, 0, 0, 0, 0, 1, 0, O_INIT, 0, 0);
    idle("mr_drain0", O_INIT);
    idle("mr_drain1", O_INIT);
    drive("mr_after", 0, 0, 0, 0, 0, 0, 1, 0, 0, O_JMP,  0, 1);
    idle("final", O_NORM);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
